// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder. It adds one 4-bit nibble per clock,
//   starting with the least-significant nibble, and keeps the carry between
//   nibbles in a register. When the last nibble is done, the result is
//   loaded into the output registers and done pulses high for one cycle.
//
// Ports
//   clk       : clock; all state changes on the rising edge
//   rst       : synchronous active-high reset; aborts any computation
//   start     : request; sampled only in IDLE
//   a, b, cin : operands and carry-in; latched when start is accepted
//   busy      : high while nibbles are being processed
//   done      : one-cycle completion pulse
//   sum       : registered WIDTH-bit result; holds until the next completion
//   cout      : carry out of bit WIDTH-1
//   overflow  : two's-complement overflow of a+b+cin
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_w, b_w, sum_w, sum_upd;
    logic             carry_r;
    logic [IW-1:0]    idx;
    logic [31:0]      base;
    logic [4:0]       nib_res;
    logic             last;

    // One nibble of the addition. sum_upd is sum_w with the current nibble
    // filled in, so the final edge can load the output directly from it.
    always_comb begin
        base    = 32'(idx) << 2;
        nib_res = {1'b0, a_w[base +: 4]} + {1'b0, b_w[base +: 4]} + {4'b0, carry_r};
        sum_upd = sum_w;
        sum_upd[base +: 4] = nib_res[3:0];
        last    = (idx == LAST_IDX);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_w      <= '0;
            b_w      <= '0;
            sum_w    <= '0;
            carry_r  <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_w     <= a;
                        b_w     <= b;
                        carry_r <= cin;
                        sum_w   <= '0;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    sum_w   <= sum_upd;
                    carry_r <= nib_res[4];
                    // The index stops at the last nibble, so it never wraps.
                    if (!last) idx <= idx + IW'(1);
                    if (last) begin
                        sum      <= sum_upd;
                        cout     <= nib_res[4];
                        // The operands have the same sign, but the result has a different sign.
                        overflow <= (a_w[WIDTH-1] == b_w[WIDTH-1]) &&
                                    (sum_upd[WIDTH-1] != a_w[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout, overflow;
    logic [W-1:0] sum;

    int n_chk = 0;
    int n_fail = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: compute the full-width unsigned sum and the signed range check.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                         output logic [W-1:0] s, output logic co, output logic ov);
        int unsigned u;
        int          si;
        u  = int'(ma) + int'(mb) + int'(mc);
        s  = u[W-1:0];
        co = u[W];
        si = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
        ov = (si > 32767) || (si < -32768);
    endtask

    // Wait for done, counting edges after the accept edge (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            chk("busy_done_excl", 32'(busy & done), 0);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);            // after accept edge E0
        start = 1'b0;
        chk({name, "_busy"}, 32'(busy), 1);
        wait_done(n);
        chk({name, "_latency"}, n, 4);
        chk({name, "_busy_at_done"}, 32'(busy), 0);
        chk({name, "_sum"}, 32'(sum), 32'(es));
        chk({name, "_cout"}, 32'(cout), 32'(ec));
        chk({name, "_ovf"}, 32'(overflow), 32'(eo));
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 0);
        chk({name, "_sum_hold"}, 32'(sum), 32'(es));
    endtask

    initial begin
        vec_t vt[6];
        int n;
        logic [W-1:0] ra, rb, ms;
        logic rc, mc, mo;

        vt[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0};
        vt[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        // Reset with start high: reset wins.
        rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 6; i++)
            do_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].sum, vt[i].cout, vt[i].ovf);

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            model(ra, rb, rc, ms, mc, mo);
            do_op($sformatf("rnd%0d", i), ra, rb, rc, ms, mc, mo);
        end

        // Start is held high and the operands change during RUN.
        @(negedge clk);
        a = 16'h0102; b = 16'h0304; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555;
        wait_done(n);
        chk("ign_latency", n, 4);
        chk("ign_sum", 32'(sum), 32'h0406);
        @(negedge clk);              // after E_NIB+1: IDLE
        chk("ign_idle_done", 32'(done), 0);
        chk("ign_idle_busy", 32'(busy), 0);
        @(negedge clk);              // after E_NIB+2: second run accepted
        chk("ign_second_busy", 32'(busy), 1);
        start = 1'b0;
        wait_done(n);
        chk("ign2_latency", n, 4);
        chk("ign2_sum", 32'(sum), 32'hFFFF);
        chk("ign2_cout", 32'(cout), 0);
        chk("ign2_ovf", 32'(overflow), 0);
        @(negedge clk);

        // Make the outputs nonzero, then reset during a run.
        do_op("pre_rst", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk);              // after E0
        start = 1'b0;
        @(negedge clk);              // after E1
        rst = 1'b1;
        @(negedge clk);              // after E2
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_sum", 32'(sum), 0);
        chk("mid_rst_cout", 32'(cout), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_rst_no_done", 32'(done | busy), 0);
        end
        do_op("post_rst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle N-bit adder that adds wide operands one 4-bit nibble per clock, least-significant nibble first, with a registered inter-nibble carry. It reuses the team's 4-bit full-adder datapath shape and sits between operand sources and consumers that need sums wider than 4 bits. It accepts a start request, runs for WIDTH/4 cycles, then presents a registered sum, carry-out and signed overflow with a one-cycle done pulse.

## Interface
- WIDTH, 16: operand and sum width; must be a multiple of 4 and ≥ 4; NIB = WIDTH/4.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- cin  input  1  carry into nibble 0; latched on accepted start.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse; result outputs valid from this cycle on.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow of a+b+cin.

## Operation
- Clock is clk. Reset is rst: synchronous, active-high.
- States are IDLE, RUN and DONE.
- IDLE → RUN when start=1:
  - latch a, b and cin into working registers;
  - set the nibble index to 0 and assert busy.
- RUN, one nibble per cycle:
  - {c, s} = a_w[4i+3:4i] + b_w[4i+3:4i] + carry_r (5-bit result);
  - write s into sum_w[4i+3:4i] and set carry_r to c;
  - increment the index.
- RUN → DONE on the cycle processing nibble NIB-1. On that same edge:
  - sum is loaded from the completed sum_w;
  - cout is loaded from the final carry;
  - overflow is set to (a_w[WIDTH-1] == b_w[WIDTH-1]) && (final sum[WIDTH-1] != a_w[WIDTH-1]);
  - done goes to 1 and busy goes to 0.
- DONE → IDLE unconditionally after one cycle; done returns to 0.
- start is ignored in RUN and DONE. It is not queued, and latched operands are unaffected by input changes.
- sum, cout and overflow change only at completion. They otherwise hold their last values.
- Index arithmetic: the index counts 0..NIB-1 and never wraps inside a run. It uses a width of clog2(NIB), minimum 1 bit.
- Nibble arithmetic is unsigned 4+4+1 into 5 bits. No carry is lost between nibbles.

## Timing
- Reset values: state = IDLE; busy, done, sum, cout, overflow = 0; working registers and carry_r = 0.
- rst during RUN or DONE aborts the computation:
  - next cycle is IDLE with all outputs 0;
  - no done pulse is produced;
  - rst has priority over start.
- Latency, with start sampled high at edge E0 in IDLE:
  - busy = 1 after E0;
  - nibbles are processed at edges E1..E_NIB;
  - done = 1 and results are valid after E_NIB;
  - done = 0 after E_NIB+1.
- For WIDTH=16: done follows start by 4 edges. For WIDTH=4: done follows start by 1 edge.
- Throughput: the next start is accepted no earlier than edge E_NIB+2, giving one computation per NIB+2 cycles.
- busy and done are never high in the same cycle.

## Test plan
All scenarios use WIDTH=16.
- Basic add: a=0x1234, b=0x1111, cin=0 → sum=0x2345, cout=0, overflow=0. done rises exactly 4 edges after start and is high for exactly 1 cycle.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. The same ripple with a=0x000F, b=0x0000, cin=1 → sum=0x0010, cout=0.
- Signed overflow, positive: a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, overflow=1.
- Signed overflow, negative: a=0x8000, b=0x8000 → sum=0x0000, cout=1, overflow=1.
- Ignored start: start held high through RUN, and a/b changed to 0xAAAA/0x5555 after E0 → result is from the first operands only. The second computation begins at E_NIB+2.
- Reset mid-run: rst asserted one cycle after E1 (before nibble 1 completes) → busy=0, sum=0, cout=0, overflow=0 next cycle, and no done pulse. A following start with a=0x0001, b=0x0002 → sum=0x0003.
